// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one byte-lane data RAM port between instruction fetch
//               and load/store, with alignment checks and anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic                  d_signed,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic [1:0]            ram_size,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
  localparam logic [3:0] c_cnt_max      = 4'hF;

  typedef enum logic [0:0] {
    PRI_D = 1'b0,
    PRI_I = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_starve_cnt, w_starve_nxt, w_starve_inc;
  logic        w_grant_i, w_grant_d;
  logic        w_i_err, w_d_err;
  logic [31:0] w_lane_data, w_load_data;

  logic        r_i_rvalid, r_i_err, r_d_rvalid, r_d_err;
  logic [31:0] r_i_rdata, r_d_rdata;

  assign w_i_err = |i_addr[1:0];
  assign w_d_err = (d_size == 2'b11) ||
                   ((d_size == 2'b01) && d_addr[0]) ||
                   ((d_size == 2'b10) && (|d_addr[1:0]));

  // No grants at all while reset is asserted.
  assign w_grant_i = rst && i_req && (!d_req || (r_state == PRI_I));
  assign w_grant_d = rst && d_req && !w_grant_i;
  assign i_ready   = w_grant_i;
  assign d_ready   = w_grant_d;

  assign w_starve_inc = (r_starve_cnt == c_cnt_max) ? r_starve_cnt : r_starve_cnt + 4'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    if (w_grant_i) begin
      w_state_nxt  = PRI_D;
      w_starve_nxt = 4'd0;
    end else if (rst && i_req) begin
      w_starve_nxt = w_starve_inc;
      if ((r_state == PRI_D) && (w_starve_inc >= c_starve_limit))
        w_state_nxt = PRI_I;
    end
  end

  always_comb begin
    case (d_size)
      2'b00:   w_lane_data = {4{d_wdata[7:0]}};
      2'b01:   w_lane_data = {2{d_wdata[15:0]}};
      default: w_lane_data = d_wdata;
    endcase
  end

  always_comb begin
    case (d_size)
      2'b00:   w_load_data = {{24{d_signed & ram_rdata[7]}}, ram_rdata[7:0]};
      2'b01:   w_load_data = {{16{d_signed & ram_rdata[15]}}, ram_rdata[15:0]};
      default: w_load_data = ram_rdata;
    endcase
  end

  always_comb begin
    ram_size  = 2'b10;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_grant_i) begin
      ram_addr = i_addr;
    end else if (w_grant_d) begin
      ram_size  = d_size;
      ram_we    = d_we && !w_d_err;
      ram_addr  = d_addr;
      ram_wdata = w_lane_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= PRI_D;
      r_starve_cnt <= 4'd0;
      r_i_rvalid   <= 1'b0;
      r_i_err      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rvalid   <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_i_rvalid   <= w_grant_i;
      r_i_err      <= w_grant_i && w_i_err;
      r_i_rdata    <= (w_grant_i && !w_i_err) ? ram_rdata : 32'd0;
      r_d_rvalid   <= w_grant_d;
      r_d_err      <= w_grant_d && w_d_err;
      r_d_rdata    <= (w_grant_d && !d_we && !w_d_err) ? w_load_data : 32'd0;
    end
  end

  // A response due during a reset cycle is dropped rather than presented.
  assign i_rvalid = rst && r_i_rvalid;
  assign i_err    = rst && r_i_err;
  assign i_rdata  = rst ? r_i_rdata : 32'd0;
  assign d_rvalid = rst && r_d_rvalid;
  assign d_err    = rst && r_d_err;
  assign d_rdata  = rst ? r_d_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Scoreboard bench with a byte-array RAM and reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int c_limit = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_ready, i_rvalid, i_err;
  logic [9:0]  i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_signed, d_ready, d_rvalid, d_err;
  logic [1:0]  d_size;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [1:0]  ram_size;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'd0;

  ram_port_arbiter #(.ADDR_WIDTH(10), .STARVE_LIMIT(c_limit)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .ram_size(ram_size), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Device RAM: byte lanes written at posedge, right-aligned read registered at negedge.
  logic [7:0] dev_mem [0:1023];
  logic [7:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (ram_we) begin
      case (ram_size)
        2'b00: dev_mem[ram_addr] <= ram_wdata[8*int'(ram_addr[1:0]) +: 8];
        2'b01: begin
          dev_mem[{ram_addr[9:1], 1'b0}] <= ram_wdata[16*int'(ram_addr[1]) +: 8];
          dev_mem[{ram_addr[9:1], 1'b1}] <= ram_wdata[16*int'(ram_addr[1]) + 8 +: 8];
        end
        default: for (int k = 0; k < 4; k++) dev_mem[{ram_addr[9:2], 2'(k)}] <= ram_wdata[8*k +: 8];
      endcase
    end
  end

  always @(negedge clk) begin
    case (ram_size)
      2'b00:   ram_rdata <= {24'd0, dev_mem[ram_addr]};
      2'b01:   ram_rdata <= {16'd0, dev_mem[{ram_addr[9:1], 1'b1}], dev_mem[{ram_addr[9:1], 1'b0}]};
      default: ram_rdata <= {dev_mem[{ram_addr[9:2], 2'd3}], dev_mem[{ram_addr[9:2], 2'd2}],
                             dev_mem[{ram_addr[9:2], 2'd1}], dev_mem[{ram_addr[9:2], 2'd0}]};
    endcase
  end

  // Reference model: memory as bytes, access as n = 2**size little-endian bytes.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t iq[$];
  rsp_t dq[$];

  function automatic logic [31:0] ref_load(input int a, input int size, input bit sgn);
    int n = 1 << size;
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  int denied = 0;
  bit prio_i = 1'b0;
  bit last_gi = 1'b0;
  bit last_gd = 1'b0;

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      prio_i  = 1'b0;
      denied  = 0;
      last_gi = 1'b0;
      last_gd = 1'b0;
      chk("reset_ready_we", {29'd0, i_ready, d_ready, ram_we}, 32'd0);
    end else begin
      bit gi, gd, derr;
      int a, sz;
      gi = i_req && (!d_req || prio_i);
      gd = d_req && !gi;
      chk("grant", {30'd0, i_ready, d_ready}, {30'd0, gi, gd});
      if (gi) begin
        if (i_addr % 4 != 0) iq.push_back('{32'd0, 1'b1});
        else iq.push_back('{ref_load(int'(i_addr), 2, 1'b0), 1'b0});
      end
      if (gd) begin
        a    = int'(d_addr);
        sz   = int'(d_size);
        derr = (sz == 3) || (a % (1 << sz) != 0);
        chk("ram_we", {31'd0, ram_we}, {31'd0, d_we && !derr});
        if (derr) dq.push_back('{32'd0, 1'b1});
        else if (d_we) begin
          for (int k = 0; k < (1 << sz); k++) ref_mem[a + k] = d_wdata[8*k +: 8];
          dq.push_back('{32'd0, 1'b0});
        end else dq.push_back('{ref_load(a, sz, d_signed), 1'b0});
      end
      if (gi) begin
        denied = 0;
        prio_i = 1'b0;
      end else if (i_req) begin
        if (denied < 15) denied++;
        if (denied >= c_limit) prio_i = 1'b1;
      end
      last_gi = gi;
      last_gd = gd;
    end
  end

  // Monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      chk("reset_rsp", {i_rvalid, d_rvalid, i_err, d_err} | (|{i_rdata, d_rdata} ? 32'd1 : 32'd0), 32'd0);
      iq.delete();
      dq.delete();
    end else begin
      if (i_rvalid) begin
        if (iq.size() == 0) chk("i_spurious_rvalid", 32'd1, 32'd0);
        else begin
          e = iq.pop_front();
          chk("i_rdata", i_rdata, e.rdata);
          chk("i_err", {31'd0, i_err}, {31'd0, e.err});
        end
      end else if (iq.size() != 0) begin
        void'(iq.pop_front());
        chk("i_missing_rvalid", 32'd0, 32'd1);
      end
      if (d_rvalid) begin
        if (dq.size() == 0) chk("d_spurious_rvalid", 32'd1, 32'd0);
        else begin
          e = dq.pop_front();
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_err", {31'd0, d_err}, {31'd0, e.err});
        end
      end else if (dq.size() != 0) begin
        void'(dq.pop_front());
        chk("d_missing_rvalid", 32'd0, 32'd1);
      end
    end
  end

  task automatic d_op(input logic we, input logic [1:0] sz, input logic sg, input logic [9:0] a,
                      input logic [31:0] wd, output logic rdy_seen, output logic we_seen);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b1; d_we = we; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
    #2;
    rdy_seen = d_ready;
    we_seen  = ram_we;
    @(posedge clk); #1;
    d_req = 1'b0;
    #2;
  endtask

  initial begin
    logic rdy, wes;
    logic [7:0] b;
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      dev_mem[i] = b;
      ref_mem[i] = b;
    end
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'b10; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Both requesters held for six cycles straight out of reset.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 10'h010; d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 10'h014;
    for (int c = 0; c < 6; c++) begin
      #2;
      chk("starve_d_ready", {31'd0, d_ready}, {31'd0, c != 4});
      chk("starve_i_ready", {31'd0, i_ready}, {31'd0, c == 4});
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0;

    d_op(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEAD_BEEF, rdy, wes);
    chk("st_word_we", {31'd0, wes}, 32'd1);
    d_op(1'b0, 2'b10, 1'b0, 10'h010, 32'd0, rdy, wes);
    chk("ld_word_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("ld_word_data", d_rdata, 32'hDEAD_BEEF);
    chk("ld_word_err", {31'd0, d_err}, 32'd0);

    d_op(1'b1, 2'b00, 1'b0, 10'h013, 32'h0000_0080, rdy, wes);
    d_op(1'b0, 2'b00, 1'b1, 10'h013, 32'd0, rdy, wes);
    chk("ld_sbyte", d_rdata, 32'hFFFF_FF80);
    d_op(1'b0, 2'b00, 1'b0, 10'h013, 32'd0, rdy, wes);
    chk("ld_ubyte", d_rdata, 32'h0000_0080);
    d_op(1'b0, 2'b10, 1'b0, 10'h010, 32'd0, rdy, wes);
    chk("ld_word_merged", d_rdata, 32'h80AD_BEEF);

    d_op(1'b0, 2'b01, 1'b0, 10'h011, 32'd0, rdy, wes);
    chk("mis_half_ready", {31'd0, rdy}, 32'd1);
    chk("mis_half_we", {31'd0, wes}, 32'd0);
    chk("mis_half_err", {31'd0, d_err}, 32'd1);
    chk("mis_half_data", d_rdata, 32'd0);
    d_op(1'b1, 2'b01, 1'b0, 10'h011, 32'h0000_5555, rdy, wes);
    chk("mis_half_st_we", {31'd0, wes}, 32'd0);
    d_op(1'b0, 2'b10, 1'b0, 10'h010, 32'd0, rdy, wes);
    chk("ram_unchanged", d_rdata, 32'h80AD_BEEF);

    d_op(1'b1, 2'b10, 1'b0, 10'h014, 32'h1234_5678, rdy, wes);
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 10'h010;
    @(posedge clk); #1;
    i_addr = 10'h014;
    #2;
    chk("fetch0_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("fetch0_data", i_rdata, 32'h80AD_BEEF);
    @(posedge clk); #1;
    i_req = 1'b0;
    #2;
    chk("fetch1_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("fetch1_data", i_rdata, 32'h1234_5678);

    // Reset in the cycle after a load grant.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 10'h010;
    @(posedge clk); #1;
    rst = 1'b0; i_req = 1'b1; i_addr = 10'h014;
    #2;
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("post_rst_pri_d", {30'd0, i_ready, d_ready}, 32'd1);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;

    // Randomised traffic; each requester holds its request until accepted.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (!i_req || last_gi) begin
        i_req  = ($urandom % 3) != 0;
        i_addr = 10'(($urandom % 16) * 4 + ((($urandom % 8) == 0) ? ($urandom % 4) : 0));
      end
      if (!d_req || last_gd) begin
        int s;
        d_req    = ($urandom % 3) != 0;
        d_we     = 1'($urandom);
        d_signed = 1'($urandom);
        d_wdata  = $urandom;
        s        = int'($urandom % 8);
        d_size   = (s < 2) ? 2'b00 : (s < 4) ? 2'b01 : (s < 7) ? 2'b10 : 2'b11;
        d_addr   = 10'($urandom % 64);
        if (($urandom % 6) != 0 && d_size != 2'b11)
          d_addr = d_addr & ~(10'((1 << int'(d_size)) - 1));
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
